// File: rtl/mix_char_pkg.sv
// rtl/mix_char_pkg.sv - MIX word geometry, CHAR encoding constants and FSM state type
package mix_char_pkg;

  localparam int BYTE_W     = 6;
  localparam int WORD_BYTES = 5;
  localparam int WORD_W     = BYTE_W * WORD_BYTES;
  localparam int DIGITS     = 2 * WORD_BYTES;
  localparam int BCD_W      = 4 * DIGITS;

  localparam logic [BYTE_W-1:0] CHAR_DIGIT0 = 6'd30;

  // One step per input bit; the step counter holds (step number - 1)
  localparam logic [4:0] LAST_STEP = 5'd29;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // MIX character code for a decimal digit
  function automatic logic [BYTE_W-1:0] char_code(input logic [3:0] digit);
    return CHAR_DIGIT0 + {2'b00, digit};
  endfunction

endpackage

// File: rtl/mix_char_if.sv
// rtl/mix_char_if.sv - request/result bundle between the MIX sequencer and mix_char
interface mix_char_if;
  import mix_char_pkg::*;

  logic              start;
  logic [WORD_W-1:0] in;
  logic [WORD_W-1:0] a_out;
  logic [WORD_W-1:0] x_out;
  logic              busy;
  logic              done;

  modport master (output start, output in, input a_out, input x_out, input busy, input done);
  modport slave  (input start, input in, output a_out, output x_out, output busy, output done);

endinterface

// File: rtl/mix_char_bcd_add3.sv
// rtl/mix_char_bcd_add3.sv - double-dabble nibble correction (add 3 when >= 5)
module mix_char_bcd_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  // A nibble >= 5 would exceed 9 after the next shift, so pre-bias it by 3
  assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/mix_char.sv
// rtl/mix_char.sv - 30-bit binary to ten MIX character codes (CHAR datapath)
module mix_char
  import mix_char_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  mix_char_if.slave  bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WORD_W-1:0] r_bin;
  logic [BCD_W-1:0]  r_bcd;
  logic [4:0]        r_cnt;
  logic              r_done;
  logic [WORD_W-1:0] r_a;
  logic [WORD_W-1:0] r_x;

  logic [BCD_W-1:0]  w_bcd_adj;
  logic [BCD_W-1:0]  w_bcd_nxt;
  logic [WORD_W-1:0] w_bin_nxt;
  logic              w_last;
  logic [WORD_W-1:0] w_a;
  logic [WORD_W-1:0] w_x;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    mix_char_bcd_add3 u_add3 (
      .i_nib (r_bcd[4*g +: 4]),
      .o_nib (w_bcd_adj[4*g +: 4])
    );
  end

  // The bit shifted out of the top nibble is always 0: 2^30-1 has only ten digits
  assign {w_bcd_nxt, w_bin_nxt} = {w_bcd_adj, r_bin} << 1;
  assign w_last = (r_cnt == LAST_STEP);

  // Encode the post-step BCD value so the result lands on the same edge as done
  always_comb begin
    w_a = '0;
    w_x = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      w_x[BYTE_W*i +: BYTE_W] = char_code(w_bcd_nxt[4*i +: 4]);
      w_a[BYTE_W*i +: BYTE_W] = char_code(w_bcd_nxt[4*(i+WORD_BYTES) +: 4]);
    end
  end

  // Next-state: start is only honoured in IDLE, RUN ends after the last step
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Shift datapath, step counter and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_a    <= '0;
      r_x    <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (bus.start) begin
          r_bin <= bus.in;
          r_bcd <= '0;
          r_cnt <= '0;
        end
      end else begin
        r_bin <= w_bin_nxt;
        r_bcd <= w_bcd_nxt;
        r_cnt <= r_cnt + 5'd1;
        if (w_last) begin
          r_done <= 1'b1;
          r_a    <= w_a;
          r_x    <= w_x;
        end
      end
    end
  end

  assign bus.busy  = (r_state == ST_RUN);
  assign bus.done  = r_done;
  assign bus.a_out = r_a;
  assign bus.x_out = r_x;

endmodule

// File: tb/tb_mix_char.sv
// tb/tb_mix_char.sv - self-checking bench for mix_char against a decimal-arithmetic model
module tb_mix_char;

  logic clk;
  logic reset;
  mix_char_if bus ();

  mix_char dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  logic chk_en = 1'b0;

  // Reference: when a conversion would finish and what the ten digits are
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_cnt  = 0;
  int unsigned m_val  = 0;
  logic [29:0] m_a    = '0;
  logic [29:0] m_x    = '0;

  function automatic logic [59:0] enc(input int unsigned v);
    logic [59:0] r;
    int unsigned t;
    t = v;
    for (int i = 0; i < 10; i++) begin
      r[6*i +: 6] = 6'(30 + (t % 10));
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o (octal) expected %0o (octal) at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [59:0] r;
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_a = '0; m_x = '0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == 30) begin
          r = enc(m_val);
          m_a = r[59:30];
          m_x = r[29:0];
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (bus.start) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        m_val  = bus.in;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",  {31'd0, bus.busy}, {31'd0, m_busy});
      check("done",  {31'd0, bus.done}, {31'd0, m_done});
      check("a_out", {2'd0, bus.a_out}, {2'd0, m_a});
      check("x_out", {2'd0, bus.x_out}, {2'd0, m_x});
      if (bus.done) done_seen++;
    end
  end

  task automatic pulse(input logic [29:0] v);
    bus.start = 1'b1;
    bus.in    = v;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    bus.in    = ~v;
  endtask

  task automatic wait_done(input string nm, input logic [29:0] ea, input logic [29:0] ex, input int lat);
    int n;
    n = 0;
    while (n < 45) begin
      @(negedge clk);
      n++;
      if (bus.done === 1'b1) break;
    end
    if (bus.done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: done not seen after %0d cycles", nm, n);
    end else begin
      check({nm, "_latency"}, 32'(n - 1), 32'(lat));
      check({nm, "_a"}, {2'd0, bus.a_out}, {2'd0, ea});
      check({nm, "_x"}, {2'd0, bus.x_out}, {2'd0, ex});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [59:0] p;
    int d0;

    p = enc(100963136);
    check("model_pin_a", {2'd0, p[59:30]}, {2'd0, 30'o3637363647});
    check("model_pin_x", {2'd0, p[29:0]},  {2'd0, 30'o4441374144});
    p = enc(32'd1073741823);
    check("model_pin_max_a", {2'd0, p[59:30]}, {2'd0, 30'o3736454145});

    reset = 1'b1;
    bus.start = 1'b0;
    bus.in = '0;
    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_a",    {2'd0, bus.a_out}, 32'd0);
    check("rst_x",    {2'd0, bus.x_out}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);

    @(posedge clk);
    #2;
    pulse(30'o0601111500);
    wait_done("basic", 30'o3637363647, 30'o4441374144, 30);

    repeat (2) @(posedge clk);
    #2;
    pulse(30'd0);
    wait_done("zero", 30'o3636363636, 30'o3636363636, 30);
    pulse(30'd9);
    wait_done("b2b", 30'o3636363636, 30'o3636363647, 30);

    repeat (3) @(posedge clk);
    #2;
    pulse(30'o7777777777);
    wait_done("max", 30'o3736454145, 30'o4237464041, 30);

    repeat (3) @(posedge clk);
    #2;
    d0 = done_seen;
    pulse(30'o0601111500);
    repeat (5) @(posedge clk);
    #2;
    pulse(30'd12345);
    wait_done("ignore", 30'o3637363647, 30'o4441374144, 24);
    repeat (35) @(negedge clk);
    check("ignore_one_done", 32'(done_seen - d0), 32'd1);

    @(posedge clk);
    #2;
    pulse(30'd987654321);
    repeat (14) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("abort_a",    {2'd0, bus.a_out}, 32'd0);
    check("abort_x",    {2'd0, bus.x_out}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    d0 = done_seen;
    repeat (40) @(negedge clk);
    check("abort_no_done", 32'(done_seen - d0), 32'd0);

    @(posedge clk);
    #2;
    pulse(30'd1);
    wait_done("one", 30'o3636363636, 30'o3636363637, 30);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
